// File: rtl/scrod_trig_responder_if.sv
// Trigger-link interface of the SCROD trigger responder.
// Groups the crate trigger line, the local readout handshake, the counter clear
// and the status outputs exported to the SCROD register file.
//   slave  : seen by the responder (inputs TRG/ENABLE/READOUT_DONE/CLEAR, drives the rest)
//   master : seen by the crate/readout side or a bench driving the responder
interface scrod_trig_responder_if;
  logic        TRG;           // async trigger line from crate
  logic        ENABLE;        // 1 = accept triggers
  logic        READOUT_DONE;  // 1-cycle pulse: event read out
  logic        CLEAR;         // sync clear of counters and TIMEOUT_FLAG
  logic        ACK;           // ACK_WIDTH-cycle acknowledge to crate
  logic        TRG_LOCAL;     // 1-cycle trigger to local readout
  logic        BUSY;          // high outside IDLE
  logic [31:0] TRG_COUNT;     // accepted triggers, wrapping
  logic [15:0] MISSED_COUNT;  // edges seen while busy, saturating
  logic        TIMEOUT_FLAG;  // sticky readout timeout

  modport slave (
    input  TRG, ENABLE, READOUT_DONE, CLEAR,
    output ACK, TRG_LOCAL, BUSY, TRG_COUNT, MISSED_COUNT, TIMEOUT_FLAG
  );

  modport master (
    output TRG, ENABLE, READOUT_DONE, CLEAR,
    input  ACK, TRG_LOCAL, BUSY, TRG_COUNT, MISSED_COUNT, TIMEOUT_FLAG
  );
endinterface

// File: rtl/scrod_trig_responder.sv
// Far-end (SCROD side) trigger responder of the crate trigger link.
// Synchronizes TRG, issues a 1-cycle TRG_LOCAL to readout, waits for READOUT_DONE
// (or a timeout), returns an ACK pulse, then holds off before re-arming.
// Ports:
//   CLK_42MHZ : trigger-domain clock
//   RESET     : asynchronous active-high reset
//   bus       : scrod_trig_responder_if.slave (TRG, ENABLE, READOUT_DONE, CLEAR in;
//               ACK, TRG_LOCAL, BUSY, TRG_COUNT, MISSED_COUNT, TIMEOUT_FLAG out)
// Build option: define TRG_FILTER_EN to require FILT_LEN consecutive synchronized-high
// cycles before a trigger edge is accepted (glitch filter).
module scrod_trig_responder #(
  parameter int unsigned ACK_WIDTH   = 4,
  parameter int unsigned HOLDOFF_CYC = 8,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned FILT_LEN    = 3
) (
  input logic                   CLK_42MHZ,
  input logic                   RESET,
  scrod_trig_responder_if.slave bus
);

  // Elaboration-time parameter sanity checks.
  if (ACK_WIDTH < 1) begin : g_chk_ack
    $error("ACK_WIDTH must be >= 1");
  end
  if (HOLDOFF_CYC < 1) begin : g_chk_holdoff
    $error("HOLDOFF_CYC must be >= 1");
  end
  if (TIMEOUT_CYC < 2) begin : g_chk_timeout
    $error("TIMEOUT_CYC must be >= 2");
  end
  if (FILT_LEN < 1) begin : g_chk_filt
    $error("FILT_LEN must be >= 1");
  end

  // One shared phase counter covers the longest of the three timed states.
  localparam int unsigned MaxAh  = (ACK_WIDTH > HOLDOFF_CYC) ? ACK_WIDTH : HOLDOFF_CYC;
  localparam int unsigned MaxCyc = (MaxAh > TIMEOUT_CYC) ? MaxAh : TIMEOUT_CYC;
  localparam int unsigned CntW   = $clog2(MaxCyc);

  typedef enum logic [1:0] {StIdle, StWaitDone, StAcking, StHoldoff} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              trg_s1_q, trg_s2_q;
  logic              trg_edge;
  logic              done_q;
  logic              trg_local_q, trg_local_d;
  logic              ack_q, ack_d;
  logic              timeout_q;
  logic [31:0]       trg_count_q;
  logic [15:0]       missed_q;
  logic              accept, timeout_set, missed_inc;

  // 2-flop synchronizer for the asynchronous trigger line.
  always_ff @(posedge CLK_42MHZ or posedge RESET) begin
    if (RESET) begin
      trg_s1_q <= 1'b0;
      trg_s2_q <= 1'b0;
    end else begin
      trg_s1_q <= bus.TRG;
      trg_s2_q <= trg_s1_q;
    end
  end

`ifdef TRG_FILTER_EN
  localparam int unsigned HiW = $clog2(FILT_LEN + 1);
  logic [HiW-1:0] hi_cnt_q;

  // Counts consecutive synchronized-high cycles, saturating so a held line fires once.
  always_ff @(posedge CLK_42MHZ or posedge RESET) begin
    if (RESET) begin
      hi_cnt_q <= '0;
    end else if (!trg_s2_q) begin
      hi_cnt_q <= '0;
    end else if (hi_cnt_q != HiW'(FILT_LEN)) begin
      hi_cnt_q <= hi_cnt_q + 1'b1;
    end
  end

  assign trg_edge = trg_s2_q && (hi_cnt_q == HiW'(FILT_LEN - 1));
`else
  logic trg_s3_q;

  always_ff @(posedge CLK_42MHZ or posedge RESET) begin
    if (RESET) begin
      trg_s3_q <= 1'b0;
    end else begin
      trg_s3_q <= trg_s2_q;
    end
  end

  assign trg_edge = trg_s2_q && !trg_s3_q;
`endif

  // READOUT_DONE is retimed once; a pulse is kept only if it arrives in WAIT_DONE after
  // the TRG_LOCAL cycle, so a pulse coincident with (or before) TRG_LOCAL is dropped.
  always_ff @(posedge CLK_42MHZ or posedge RESET) begin
    if (RESET) begin
      done_q <= 1'b0;
    end else begin
      done_q <= bus.READOUT_DONE && (state_q == StWaitDone) && !trg_local_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    trg_local_d = 1'b0;
    ack_d       = 1'b0;
    accept      = 1'b0;
    timeout_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trg_edge && bus.ENABLE) begin
          accept      = 1'b1;
          trg_local_d = 1'b1;
          cnt_d       = '0;
          state_d     = StWaitDone;
        end
      end
      StWaitDone: begin
        if (done_q) begin
          ack_d   = 1'b1;
          cnt_d   = '0;
          state_d = StAcking;
        end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
          timeout_set = 1'b1;
          cnt_d       = '0;
          state_d     = StHoldoff;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAcking: begin
        if (cnt_q == CntW'(ACK_WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = StHoldoff;
        end else begin
          ack_d = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHoldoff: begin
        if (cnt_q == CntW'(HOLDOFF_CYC - 1)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign missed_inc = trg_edge && bus.ENABLE && (state_q != StIdle);

  always_ff @(posedge CLK_42MHZ or posedge RESET) begin
    if (RESET) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      trg_local_q <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      trg_local_q <= trg_local_d;
      ack_q       <= ack_d;
    end
  end

  // Status registers; CLEAR wins over a same-cycle increment or timeout.
  always_ff @(posedge CLK_42MHZ or posedge RESET) begin
    if (RESET) begin
      trg_count_q <= '0;
      missed_q    <= '0;
      timeout_q   <= 1'b0;
    end else if (bus.CLEAR) begin
      trg_count_q <= '0;
      missed_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      if (accept) trg_count_q <= trg_count_q + 32'd1;
      if (missed_inc && (missed_q != 16'hFFFF)) missed_q <= missed_q + 16'd1;
      if (timeout_set) timeout_q <= 1'b1;
    end
  end

  assign bus.ACK          = ack_q;
  assign bus.TRG_LOCAL    = trg_local_q;
  assign bus.BUSY         = (state_q != StIdle);
  assign bus.TRG_COUNT    = trg_count_q;
  assign bus.MISSED_COUNT = missed_q;
  assign bus.TIMEOUT_FLAG = timeout_q;

endmodule

// File: tb/tb_scrod_trig_responder.sv
// Self-checking bench for scrod_trig_responder.
// Expected TRG_LOCAL and ACK start cycles are queued when stimulus is driven and
// popped by a negedge monitor when the DUT produces them.
module tb_scrod_trig_responder;

  localparam int ACK_WIDTH   = 4;
  localparam int HOLDOFF_CYC = 8;
  localparam int TIMEOUT_CYC = 1024;
  localparam int FILT_LEN    = 3;
`ifdef TRG_FILTER_EN
  localparam int LAT = 3 + FILT_LEN - 1;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  int   exp_local[$];
  int   exp_ack[$];
  logic ack_prev = 1'b0;
  int   ack_len = 0;
  logic ack_trunc = 1'b0;

  scrod_trig_responder_if bus ();

  scrod_trig_responder #(
    .ACK_WIDTH  (ACK_WIDTH),
    .HOLDOFF_CYC(HOLDOFF_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .FILT_LEN   (FILT_LEN)
  ) dut (
    .CLK_42MHZ(clk),
    .RESET    (rst),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Just after the posedge that starts cycle t.
  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Negedge inside cycle t.
  task automatic sample(input int t);
    goto(t);
    @(negedge clk);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (bus.TRG_LOCAL) begin
      if (exp_local.size() == 0) check_eq("trg_local_unexpected", 1, 0);
      else check_eq("trg_local_cycle", cyc, exp_local.pop_front());
    end
    if (bus.ACK && !ack_prev) begin
      if (exp_ack.size() == 0) check_eq("ack_unexpected", 1, 0);
      else check_eq("ack_start_cycle", cyc, exp_ack.pop_front());
      ack_len <= 1;
    end else if (bus.ACK) begin
      ack_len <= ack_len + 1;
    end else if (ack_prev && !ack_trunc) begin
      check_eq("ack_len", ack_len, ACK_WIDTH);
    end
    ack_prev <= bus.ACK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int exp_cnt;
    exp_cnt = 0;
    bus.TRG = 1'b0;
    bus.ENABLE = 1'b1;
    bus.READOUT_DONE = 1'b0;
    bus.CLEAR = 1'b0;

    // Reset state.
    sample(3);
    check_eq("rst_ack", bus.ACK, 0);
    check_eq("rst_trg_local", bus.TRG_LOCAL, 0);
    check_eq("rst_busy", bus.BUSY, 0);
    check_eq("rst_trg_count", bus.TRG_COUNT, 0);
    check_eq("rst_missed", bus.MISSED_COUNT, 0);
    check_eq("rst_timeout", bus.TIMEOUT_FLAG, 0);
    goto(4);
    rst = 1'b0;

    // Basic event.
    t0 = cyc + 2;
    goto(t0);
    bus.TRG = 1'b1;
    exp_local.push_back(t0 + LAT);
    goto(t0 + 10); bus.TRG = 1'b0;
    goto(t0 + 20); bus.READOUT_DONE = 1'b1; exp_ack.push_back(t0 + 22);
    goto(t0 + 21); bus.READOUT_DONE = 1'b0;
    sample(t0 + 33); check_eq("basic_busy_holdoff", bus.BUSY, 1);
    sample(t0 + 34); check_eq("basic_busy_idle", bus.BUSY, 0);
    exp_cnt = 1;
    check_eq("basic_trg_count", bus.TRG_COUNT, exp_cnt);
    check_eq("basic_missed", bus.MISSED_COUNT, 0);

    // CLEAR coincident with accept: counter goes to 0, event still runs.
    t0 = cyc + 2;
    goto(t0);
    bus.TRG = 1'b1;
    exp_local.push_back(t0 + LAT);
    goto(t0 + LAT - 1); bus.CLEAR = 1'b1;
    goto(t0 + LAT); bus.CLEAR = 1'b0;
    sample(t0 + LAT); check_eq("clr_accept_count", bus.TRG_COUNT, 0);
    check_eq("clr_accept_busy", bus.BUSY, 1);
    goto(t0 + LAT + 1); bus.TRG = 1'b0;
    goto(t0 + LAT + 5); bus.READOUT_DONE = 1'b1; exp_ack.push_back(t0 + LAT + 7);
    goto(t0 + LAT + 6); bus.READOUT_DONE = 1'b0;
    sample(t0 + LAT + 19); check_eq("clr_accept_idle", bus.BUSY, 0);
    exp_cnt = 0;

    // Second edge during an event counts as missed.
    t0 = cyc + 2;
    goto(t0);
    bus.TRG = 1'b1;
    exp_local.push_back(t0 + LAT);
    goto(t0 + LAT + 1); bus.TRG = 1'b0;
    goto(t0 + 15); bus.TRG = 1'b1;
    goto(t0 + 20); bus.TRG = 1'b0; bus.READOUT_DONE = 1'b1; exp_ack.push_back(t0 + 22);
    goto(t0 + 21); bus.READOUT_DONE = 1'b0;
    sample(t0 + 34); check_eq("missed_idle", bus.BUSY, 0);
    exp_cnt = 1;
    check_eq("missed_trg_count", bus.TRG_COUNT, exp_cnt);
    check_eq("missed_count", bus.MISSED_COUNT, 1);

    // ENABLE low while idle: edge ignored and not counted.
    t0 = cyc + 2;
    goto(t0);
    bus.ENABLE = 1'b0; bus.TRG = 1'b1;
    goto(t0 + 8); bus.TRG = 1'b0;
    sample(t0 + 10); check_eq("dis_busy", bus.BUSY, 0);
    check_eq("dis_trg_count", bus.TRG_COUNT, exp_cnt);
    check_eq("dis_missed", bus.MISSED_COUNT, 1);
    goto(t0 + 11); bus.ENABLE = 1'b1;

    // Early READOUT_DONE ignored; ENABLE dropped mid-event still completes.
    t0 = cyc + 2;
    goto(t0);
    bus.TRG = 1'b1;
    exp_local.push_back(t0 + LAT);
    goto(t0 + LAT); bus.READOUT_DONE = 1'b1;
    goto(t0 + LAT + 1); bus.READOUT_DONE = 1'b0; bus.TRG = 1'b0;
    goto(t0 + LAT + 2); bus.ENABLE = 1'b0;
    sample(t0 + LAT + 8); check_eq("early_busy", bus.BUSY, 1);
    check_eq("early_no_ack", bus.ACK, 0);
    goto(t0 + 30); bus.READOUT_DONE = 1'b1; exp_ack.push_back(t0 + 32);
    goto(t0 + 31); bus.READOUT_DONE = 1'b0;
    sample(t0 + 44); check_eq("early_idle", bus.BUSY, 0);
    exp_cnt = 2;
    check_eq("early_trg_count", bus.TRG_COUNT, exp_cnt);
    goto(t0 + 45); bus.ENABLE = 1'b1;

    // Timeout: no READOUT_DONE, no ACK, sticky flag, then CLEAR.
    t0 = cyc + 2;
    goto(t0);
    bus.TRG = 1'b1;
    exp_local.push_back(t0 + LAT);
    goto(t0 + LAT + 1); bus.TRG = 1'b0;
    sample(t0 + LAT + TIMEOUT_CYC - 1); check_eq("to_flag_before", bus.TIMEOUT_FLAG, 0);
    check_eq("to_busy_wait", bus.BUSY, 1);
    sample(t0 + LAT + TIMEOUT_CYC); check_eq("to_flag_set", bus.TIMEOUT_FLAG, 1);
    sample(t0 + LAT + TIMEOUT_CYC + HOLDOFF_CYC - 1); check_eq("to_busy_holdoff", bus.BUSY, 1);
    sample(t0 + LAT + TIMEOUT_CYC + HOLDOFF_CYC); check_eq("to_busy_idle", bus.BUSY, 0);
    check_eq("to_flag_sticky", bus.TIMEOUT_FLAG, 1);
    exp_cnt = 3;
    check_eq("to_trg_count", bus.TRG_COUNT, exp_cnt);
    t0 = cyc + 1;
    goto(t0); bus.CLEAR = 1'b1;
    goto(t0 + 1); bus.CLEAR = 1'b0;
    sample(t0 + 1); check_eq("clr_flag", bus.TIMEOUT_FLAG, 0);
    check_eq("clr_trg_count", bus.TRG_COUNT, 0);
    check_eq("clr_missed", bus.MISSED_COUNT, 0);
    exp_cnt = 0;

`ifdef TRG_FILTER_EN
    // Glitch shorter than the filter is dropped; a 3-cycle pulse is accepted.
    t0 = cyc + 2;
    goto(t0);
    bus.TRG = 1'b1;
    goto(t0 + 2); bus.TRG = 1'b0;
    sample(t0 + 10); check_eq("filt_glitch_busy", bus.BUSY, 0);
    check_eq("filt_glitch_count", bus.TRG_COUNT, exp_cnt);
    t0 = cyc + 2;
    goto(t0);
    bus.TRG = 1'b1;
    exp_local.push_back(t0 + 5);
    goto(t0 + 3); bus.TRG = 1'b0;
    goto(t0 + 10); bus.READOUT_DONE = 1'b1; exp_ack.push_back(t0 + 12);
    goto(t0 + 11); bus.READOUT_DONE = 1'b0;
    sample(t0 + 24); check_eq("filt_idle", bus.BUSY, 0);
    exp_cnt = exp_cnt + 1;
    check_eq("filt_trg_count", bus.TRG_COUNT, exp_cnt);
`endif

    // RESET during the second ACK cycle truncates the ACK at once.
    t0 = cyc + 2;
    goto(t0);
    bus.TRG = 1'b1;
    exp_local.push_back(t0 + LAT);
    goto(t0 + LAT + 1); bus.TRG = 1'b0;
    goto(t0 + 20); bus.READOUT_DONE = 1'b1; exp_ack.push_back(t0 + 22);
    goto(t0 + 21); bus.READOUT_DONE = 1'b0; ack_trunc = 1'b1;
    goto(t0 + 23); rst = 1'b1;
    #1;
    check_eq("rst_mid_ack", bus.ACK, 0);
    check_eq("rst_mid_busy", bus.BUSY, 0);
    check_eq("rst_mid_count", bus.TRG_COUNT, 0);
    goto(t0 + 25); rst = 1'b0; ack_trunc = 1'b0;

    // Normal operation after reset.
    t0 = cyc + 2;
    goto(t0);
    bus.TRG = 1'b1;
    exp_local.push_back(t0 + LAT);
    goto(t0 + LAT + 1); bus.TRG = 1'b0;
    goto(t0 + 12); bus.READOUT_DONE = 1'b1; exp_ack.push_back(t0 + 14);
    goto(t0 + 13); bus.READOUT_DONE = 1'b0;
    sample(t0 + 26); check_eq("post_rst_idle", bus.BUSY, 0);
    check_eq("post_rst_count", bus.TRG_COUNT, 1);

    sample(cyc + 4);
    check_eq("local_queue_drained", exp_local.size(), 0);
    check_eq("ack_queue_drained", exp_ack.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
